synaptic_core_mw: RTL and testbench

Parametrised synaptic memory core for tinyODIN-class neuromorphic processors. Weight width and neuron count are generic. Neuron-event and charge lookups return both the full 32-bit word and the addressed weight lane. OBI bus accesses are arbitrated against the core instead of colliding with it. Sits between the neuron controller and the system OBI crossbar. It replaces the fixed 4-bit/256-neuron synaptic array.

---
 rtl/synaptic_core_mw_if.sv | 14 +
 rtl/synaptic_core_mw.sv | 168 ++++++++++++++++
 tb/tb_synaptic_core_mw.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/synaptic_core_mw_if.sv
// OBI slave bundle between the system crossbar (master) and synaptic_core_mw (slave).
interface synaptic_core_mw_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/synaptic_core_mw.sv
// Parametrised synaptic weight memory shared by neuron-controller lookups (priority) and an OBI port.
// Optional macro SYNCORE_RMW_EN: partial byte-enable writes go through read-modify-write.
module synaptic_core_mw #(
    parameter int N = 256,
    parameter int M = 8,
    parameter int W = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              neuron_event_i,
    input  logic              charge_enable_i,
    input  logic [M-1:0]      neuron_idx_i,
    input  logic [M-1:0]      count_i,
    output logic [31:0]       synapse_data_o,
    output logic [W-1:0]      weight_o,
    output logic              weight_valid_o,
    synaptic_core_mw_if.slave obi
);
    localparam int L     = 32 / W;
    localparam int LB    = $clog2(L);
    localparam int DEPTH = N * N / L;
    localparam int AW    = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;
    logic          core;
    logic          idle;
    logic          gnt;
    logic [AW-1:0] core_addr;
    logic [AW-1:0] obi_addr;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          rvalid_d;
    logic          rvalid_q;
    logic          rd_resp_q;
    logic          core_vld_q;
    logic [LB-1:0] lane_q;
    logic [31:0]   syn_hold_q;
    logic          unused_addr;

    assign core        = neuron_event_i | charge_enable_i;
    assign core_addr   = {neuron_idx_i, count_i[M-1:LB]};
    assign obi_addr    = obi.addr[AW+1:2];
    assign unused_addr = ^{obi.addr[31:AW+2], obi.addr[1:0]};
    assign gnt         = obi.req & ~core & idle & RSTN;

`ifdef SYNCORE_RMW_EN
    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e        state_q;
    state_e        state_d;
    logic          rmw_start;
    logic          rmw_first_q;
    logic [AW-1:0] rmw_addr_q;
    logic [31:0]   rmw_wdata_q;
    logic [3:0]    rmw_be_q;
    logic [31:0]   rmw_merge_q;
    logic [31:0]   rmw_merge;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{be[b]}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    assign idle      = (state_q == IDLE);
    assign rmw_start = gnt & obi.we & (obi.be != 4'b1111) & (obi.be != 4'b0000);
    // Core lookups stalling the write overwrite rd_q, so later cycles use the merge captured on the first.
    assign rmw_merge = rmw_first_q ? merge_be(rd_q, rmw_wdata_q, rmw_be_q) : rmw_merge_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            rmw_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rmw_first_q <= rmw_start;
        end
    end

    always_ff @(posedge CLK) begin
        if (rmw_start) begin
            rmw_addr_q  <= obi_addr;
            rmw_wdata_q <= obi.wdata;
            rmw_be_q    <= obi.be;
        end
        if (rmw_first_q) rmw_merge_q <= rmw_merge;
    end

    always_comb begin
        state_d   = state_q;
        mem_addr  = obi_addr;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = obi.wdata;
        rvalid_d  = 1'b0;
        if (core) begin
            mem_addr = core_addr;
            mem_re   = 1'b1;
        end else if (state_q == RMW_WR) begin
            mem_addr  = rmw_addr_q;
            mem_we    = 1'b1;
            mem_wdata = rmw_merge;
            rvalid_d  = 1'b1;
            state_d   = IDLE;
        end else if (gnt) begin
            rvalid_d = ~rmw_start;
            mem_re   = ~obi.we | rmw_start;
            mem_we   = obi.we & (obi.be == 4'b1111);
            if (rmw_start) state_d = RMW_WR;
        end
    end
`else
    logic unused_be;

    assign idle      = 1'b1;
    assign unused_be = ^obi.be;

    always_comb begin
        mem_addr  = obi_addr;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = obi.wdata;
        rvalid_d  = 1'b0;
        if (core) begin
            mem_addr = core_addr;
            mem_re   = 1'b1;
        end else if (gnt) begin
            rvalid_d = 1'b1;
            mem_re   = ~obi.we;
            mem_we   = obi.we;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_addr];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rvalid_q   <= 1'b0;
            rd_resp_q  <= 1'b0;
            core_vld_q <= 1'b0;
            lane_q     <= '0;
            syn_hold_q <= '0;
        end else begin
            rvalid_q   <= rvalid_d;
            rd_resp_q  <= gnt & ~obi.we;
            core_vld_q <= core;
            if (core) lane_q <= count_i[LB-1:0];
            if (core_vld_q) syn_hold_q <= rd_q;
        end
    end

    // rd_q is shared with OBI reads; the last core word is held separately once the strobe drops.
    assign synapse_data_o = core_vld_q ? rd_q : syn_hold_q;
    assign weight_o       = synapse_data_o[int'(lane_q)*W +: W];
    assign weight_valid_o = core_vld_q;
    assign obi.gnt        = gnt;
    assign obi.rvalid     = rvalid_q;
    assign obi.rdata      = rd_resp_q ? rd_q : 32'h0;
endmodule

// File: tb/tb_synaptic_core_mw.sv
// Directed bench for synaptic_core_mw: defaults (N=256, W=4) plus a W=8, N=64 instance.
module tb_synaptic_core_mw;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    synaptic_core_mw_if obi_a ();
    synaptic_core_mw_if obi_b ();

    logic        ev_a, ce_a, wv_a;
    logic [7:0]  idx_a, cnt_a;
    logic [31:0] syn_a;
    logic [3:0]  wt_a;
    logic        ev_b, ce_b, wv_b;
    logic [5:0]  idx_b, cnt_b;
    logic [31:0] syn_b;
    logic [7:0]  wt_b;

    int n_cmp = 0;
    int n_err = 0;

`ifdef SYNCORE_RMW_EN
    localparam logic [31:0] BE0_EXP  = 32'h0000_00F0;
    localparam logic [31:0] PART_EXP = 32'h8765_AA21;
`else
    localparam logic [31:0] BE0_EXP  = 32'hFFFF_FFFF;
    localparam logic [31:0] PART_EXP = 32'h0000_AA00;
`endif

    synaptic_core_mw #(.N(256), .M(8), .W(4)) dut_a (
        .CLK(clk), .RSTN(rstn),
        .neuron_event_i(ev_a), .charge_enable_i(ce_a),
        .neuron_idx_i(idx_a), .count_i(cnt_a),
        .synapse_data_o(syn_a), .weight_o(wt_a), .weight_valid_o(wv_a),
        .obi(obi_a)
    );

    synaptic_core_mw #(.N(64), .M(6), .W(8)) dut_b (
        .CLK(clk), .RSTN(rstn),
        .neuron_event_i(ev_b), .charge_enable_i(ce_b),
        .neuron_idx_i(idx_b), .count_i(cnt_b),
        .synapse_data_o(syn_b), .weight_o(wt_b), .weight_valid_o(wv_b),
        .obi(obi_b)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic obi_a_drive(input logic req, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wdata);
        obi_a.req = req; obi_a.we = we; obi_a.be = be; obi_a.addr = addr; obi_a.wdata = wdata;
    endtask

    task automatic core_a(input logic ev, input logic ce, input logic [7:0] idx, input logic [7:0] cnt);
        ev_a = ev; ce_a = ce; idx_a = idx; cnt_a = cnt;
    endtask

    task automatic idle_a();
        obi_a_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        core_a(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic idle_b();
        obi_b.req = 1'b0; obi_b.we = 1'b0; obi_b.be = 4'h0; obi_b.addr = 32'h0; obi_b.wdata = 32'h0;
        ev_b = 1'b0; ce_b = 1'b0; idx_b = 6'd0; cnt_b = 6'd0;
    endtask

    task automatic write_a(input string tag, input logic [31:0] addr, input logic [31:0] data);
        tick(); obi_a_drive(1'b1, 1'b1, 4'hF, addr, data);
        sample(); check_val({tag, "_gnt"}, obi_a.gnt, 1);
        tick(); idle_a();
        sample(); check_val({tag, "_rvalid"}, obi_a.rvalid, 1);
        check_val({tag, "_rdata"}, obi_a.rdata, 0);
    endtask

    task automatic read_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        tick(); obi_a_drive(1'b1, 1'b0, 4'hF, addr, 32'h0);
        sample(); check_val({tag, "_gnt"}, obi_a.gnt, 1);
        tick(); idle_a();
        sample(); check_val({tag, "_rvalid"}, obi_a.rvalid, 1);
        check_val({tag, "_rdata"}, obi_a.rdata, exp);
    endtask

    task automatic lookup_a(input string tag, input logic ev, input logic ce, input logic [7:0] idx,
                            input logic [7:0] cnt, input logic [3:0] exp_w, input logic [31:0] exp_word);
        tick(); core_a(ev, ce, idx, cnt);
        sample();
        tick(); idle_a();
        sample(); check_val({tag, "_valid"}, wv_a, 1);
        check_val({tag, "_weight"}, wt_a, exp_w);
        check_val({tag, "_word"}, syn_a, exp_word);
    endtask

    initial begin
        rstn = 1'b0;
        idle_a();
        idle_b();
        obi_a.req = 1'b1;
        sample();
        check_val("rst_wv", wv_a, 0);
        check_val("rst_syn", syn_a, 0);
        check_val("rst_wt", wt_a, 0);
        check_val("rst_gnt", obi_a.gnt, 0);
        check_val("rst_rvalid", obi_a.rvalid, 0);
        check_val("rst_rdata", obi_a.rdata, 0);
        tick(); rstn = 1'b1; idle_a();

        // Basic write then lookups on word 4 through each request input.
        write_a("wr4", 32'h10, 32'h8765_4321);
        tick(); sample(); check_val("rvalid_drop", obi_a.rvalid, 0);
        lookup_a("lk_ev", 1'b1, 1'b0, 8'd0, 8'd33, 4'h2, 32'h8765_4321);
        tick(); sample();
        check_val("wv_drop", wv_a, 0);
        check_val("syn_hold", syn_a, 32'h8765_4321);
        lookup_a("lk_ce", 1'b0, 1'b1, 8'd0, 8'd39, 4'h8, 32'h8765_4321);
        lookup_a("lk_both", 1'b1, 1'b1, 8'd0, 8'd34, 4'h3, 32'h8765_4321);
        write_a("wr32", 32'h80, 32'h0000_000C);
        lookup_a("lk_idx1", 1'b1, 1'b0, 8'd1, 8'd0, 4'hC, 32'h0000_000C);

        // Core and OBI read in the same cycle: core wins, read is stalled one cycle.
        tick(); obi_a_drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0); core_a(1'b1, 1'b0, 8'd0, 8'd32);
        sample(); check_val("cont_gnt0", obi_a.gnt, 0);
        tick(); core_a(1'b0, 1'b0, 8'd0, 8'd0);
        sample(); check_val("cont_gnt1", obi_a.gnt, 1);
        check_val("cont_norv", obi_a.rvalid, 0);
        check_val("cont_wv", wv_a, 1);
        check_val("cont_wt", wt_a, 4'h1);
        tick(); idle_a();
        sample(); check_val("cont_rvalid", obi_a.rvalid, 1);
        check_val("cont_rdata", obi_a.rdata, 32'h8765_4321);

        // Lookup in the cycle after a write to the same word sees the new data.
        tick(); obi_a_drive(1'b1, 1'b1, 4'hF, 32'h14, 32'h0000_00F0);
        sample();
        tick(); idle_a(); core_a(1'b1, 1'b0, 8'd0, 8'd41);
        sample();
        tick(); idle_a();
        sample(); check_val("raw_wv", wv_a, 1);
        check_val("raw_wt", wt_a, 4'hF);

        // Write with no byte enables.
        tick(); obi_a_drive(1'b1, 1'b1, 4'h0, 32'h14, 32'hFFFF_FFFF);
        sample(); check_val("be0_gnt", obi_a.gnt, 1);
        tick(); idle_a();
        sample(); check_val("be0_rvalid", obi_a.rvalid, 1);
        check_val("be0_rdata", obi_a.rdata, 0);
        read_a("be0_rb", 32'h14, BE0_EXP);

        // Partial write followed by a held read request.
        tick(); obi_a_drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
        sample(); check_val("pw_gnt", obi_a.gnt, 1);
        tick(); obi_a_drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        sample();
`ifdef SYNCORE_RMW_EN
        check_val("pw_busy_gnt", obi_a.gnt, 0);
        check_val("pw_rv_t1", obi_a.rvalid, 0);
        tick(); sample();
        check_val("pw_rd_gnt", obi_a.gnt, 1);
        check_val("pw_rv_t2", obi_a.rvalid, 1);
        check_val("pw_wr_rdata", obi_a.rdata, 0);
`else
        check_val("pw_rd_gnt", obi_a.gnt, 1);
        check_val("pw_rv_t1", obi_a.rvalid, 1);
        check_val("pw_wr_rdata", obi_a.rdata, 0);
`endif
        tick(); idle_a();
        sample(); check_val("pw_rb_rvalid", obi_a.rvalid, 1);
        check_val("pw_rb_rdata", obi_a.rdata, PART_EXP);
        write_a("restore1", 32'h10, 32'h8765_4321);

        // Partial write with a core lookup in the following cycle.
        tick(); obi_a_drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
        sample(); check_val("pwc_gnt", obi_a.gnt, 1);
        tick(); idle_a(); core_a(1'b1, 1'b0, 8'd0, 8'd33);
        sample();
`ifdef SYNCORE_RMW_EN
        check_val("pwc_rv_t1", obi_a.rvalid, 0);
        tick(); idle_a();
        sample(); check_val("pwc_rv_t2", obi_a.rvalid, 0);
        check_val("pwc_wt_old", wt_a, 4'h2);
        tick();
        sample(); check_val("pwc_rv_t3", obi_a.rvalid, 1);
        check_val("pwc_rdata", obi_a.rdata, 0);
`else
        check_val("pwc_rv_t1", obi_a.rvalid, 1);
        tick(); idle_a();
        sample(); check_val("pwc_wt_new", wt_a, 4'h0);
`endif
        read_a("pwc_rb", 32'h10, PART_EXP);
        write_a("restore2", 32'h10, 32'h8765_4321);

        // Reset in the middle of a lookup with a read pending.
        tick(); core_a(1'b1, 1'b0, 8'd0, 8'd33);
        sample();
        tick(); idle_a(); rstn = 1'b0; obi_a_drive(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        sample();
        check_val("mrst_wv", wv_a, 0);
        check_val("mrst_syn", syn_a, 0);
        check_val("mrst_wt", wt_a, 0);
        check_val("mrst_gnt", obi_a.gnt, 0);
        check_val("mrst_rvalid", obi_a.rvalid, 0);
        tick(); rstn = 1'b1;
        sample(); check_val("mrst_gnt_follow", obi_a.gnt, 1);
        tick(); idle_a();
        sample(); check_val("mrst_rvalid", obi_a.rvalid, 1);
        check_val("mrst_rdata", obi_a.rdata, 32'h8765_4321);

`ifdef SYNCORE_RMW_EN
        // Reset while the merged word is pending: write dropped, no response.
        tick(); obi_a_drive(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AA00);
        sample(); check_val("rmwr_gnt", obi_a.gnt, 1);
        tick(); idle_a(); rstn = 1'b0;
        sample(); check_val("rmwr_rv1", obi_a.rvalid, 0);
        tick(); rstn = 1'b1;
        sample(); check_val("rmwr_rv2", obi_a.rvalid, 0);
        tick();
        sample(); check_val("rmwr_rv3", obi_a.rvalid, 0);
        read_a("rmwr_rb", 32'h10, 32'h8765_4321);
`endif

        // W=8, N=64 instance: byte lanes.
        tick(); obi_b.req = 1'b1; obi_b.we = 1'b1; obi_b.be = 4'hF; obi_b.addr = 32'h0; obi_b.wdata = 32'hDDCC_BBAA;
        sample(); check_val("b_wr_gnt", obi_b.gnt, 1);
        tick(); idle_b(); ev_b = 1'b1; cnt_b = 6'd2;
        sample(); check_val("b_wr_rvalid", obi_b.rvalid, 1);
        tick(); idle_b();
        sample(); check_val("b_lk_valid", wv_b, 1);
        check_val("b_lk_weight", wt_b, 8'hCC);
        check_val("b_lk_word", syn_b, 32'hDDCC_BBAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
